// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package rca_pkg;
    localparam int DEFAULT_WIDTH     = 64;
    localparam int DEFAULT_SEG_WIDTH = 16;

    function automatic int calc_stages(input int width, input int seg_width);
        return width / seg_width;
    endfunction
endpackage

// File: rtl/rca_segment.sv
// Combinational SEG_WIDTH-bit ripple-carry segment; one instance per pipeline stage.
module rca_segment
    import rca_pkg::*;
#(
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 cout
);
    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder, one SEG_WIDTH segment per stage, valid/ready flow control.
// Optional signed-overflow output OVF is built when PIPELINED_RCA_OVF_EN is defined.
module pipelined_rca
    import rca_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_Out
`ifdef PIPELINED_RCA_OVF_EN
    ,
    output logic             OVF
`endif
);
    localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // Operands still to be added (skewed); the sum accumulated so far (de-skewed).
            localparam int OP_W  = WIDTH - gi * SEG_WIDTH;
            localparam int SUM_W = (gi + 1) * SEG_WIDTH;

            logic [OP_W-1:0]      a_in;
            logic [OP_W-1:0]      b_in;
            logic                 carry_in;
            logic                 valid_in;
            logic [SEG_WIDTH-1:0] seg_sum;
            logic                 seg_cout;
            logic [SUM_W-1:0]     sum_next;
            logic [SUM_W-1:0]     sum_reg;
            logic                 carry_reg;
            logic                 valid_reg;

            if (gi == 0) begin : g_first
                assign a_in     = A;
                assign b_in     = B;
                assign carry_in = C0;
                assign valid_in = in_valid;
                assign sum_next = seg_sum;
            end else begin : g_next
                logic [OP_W-1:0] a_reg;
                logic [OP_W-1:0] b_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (advance) begin
                        a_reg <= g_stage[gi-1].a_in[OP_W+SEG_WIDTH-1:SEG_WIDTH];
                        b_reg <= g_stage[gi-1].b_in[OP_W+SEG_WIDTH-1:SEG_WIDTH];
                    end
                end

                assign a_in     = a_reg;
                assign b_in     = b_reg;
                assign carry_in = g_stage[gi-1].carry_reg;
                assign valid_in = g_stage[gi-1].valid_reg;
                assign sum_next = {seg_sum, g_stage[gi-1].sum_reg};
            end

            rca_segment #(
                .SEG_WIDTH(SEG_WIDTH)
            ) u_segment (
                .a   (a_in[SEG_WIDTH-1:0]),
                .b   (b_in[SEG_WIDTH-1:0]),
                .cin (carry_in),
                .s   (seg_sum),
                .cout(seg_cout)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (advance) begin
                    valid_reg <= valid_in;
                    carry_reg <= seg_cout;
                    sum_reg   <= sum_next;
                end
            end

`ifdef PIPELINED_RCA_OVF_EN
            // Operand sign bits ride along in the skew registers, so the last stage sees them.
            if (gi == STAGES - 1) begin : g_ovf
                logic ovf_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_reg <= 1'b0;
                    end else if (advance) begin
                        ovf_reg <= (a_in[OP_W-1] == b_in[OP_W-1]) &&
                                   (seg_sum[SEG_WIDTH-1] != a_in[OP_W-1]);
                    end
                end
            end
`endif
        end
    endgenerate

    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign S         = out_valid ? g_stage[STAGES-1].sum_reg : '0;
    assign C_Out     = out_valid & g_stage[STAGES-1].carry_reg;
`ifdef PIPELINED_RCA_OVF_EN
    assign OVF       = out_valid & g_stage[STAGES-1].g_ovf.ovf_reg;
`endif
endmodule

// File: tb/tb_pipelined_rca.sv
// Self-checking bench for pipelined_rca: random streams scored against an arithmetic model.
module tb_pipelined_rca;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    // Default-parameter instance
    logic         in_valid = 1'b0, in_ready, C0 = 1'b0, out_valid, out_ready = 1'b1, C_Out;
    logic [W-1:0] A = '0, B = '0, S;
    logic         ovf_bit;
    logic [65:0]  obs;

    // Parameter-sweep instances (8/8 and 32/4)
    logic        sw_valid = 1'b0, rdy8, rdy32, ov8, ov32, co8, co32, ovf8, ovf32;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic [31:0] a32 = '0, b32 = '0, s32;
    logic        c8 = 1'b0, c32 = 1'b0;

`ifdef PIPELINED_RCA_OVF_EN
    logic OVF, o8_raw, o32_raw;
    assign ovf_bit = OVF;
    assign ovf8    = o8_raw;
    assign ovf32   = o32_raw;
`else
    assign ovf_bit = 1'b0;
    assign ovf8    = 1'b0;
    assign ovf32   = 1'b0;
`endif
    assign obs = {ovf_bit, C_Out, S};

    pipelined_rca dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .C0(C0), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .C_Out(C_Out)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(OVF)
`endif
    );

    pipelined_rca #(.WIDTH(8), .SEG_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8),
        .A(a8), .B(b8), .C0(c8), .out_valid(ov8), .out_ready(1'b1),
        .S(s8), .C_Out(co8)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(o8_raw)
`endif
    );

    pipelined_rca #(.WIDTH(32), .SEG_WIDTH(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32),
        .A(a32), .B(b32), .C0(c32), .out_valid(ov32), .out_ready(1'b1),
        .S(s32), .C_Out(co32)
`ifdef PIPELINED_RCA_OVF_EN
        , .OVF(o32_raw)
`endif
    );

    // Reference: plain integer addition, result packed as {ovf, carry, sum}
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [64:0] t;
        logic        v;
        t = {1'b0, a} + {1'b0, b} + {64'd0, c};
`ifdef PIPELINED_RCA_OVF_EN
        v = (a[63] == b[63]) && (t[63] != a[63]);
`else
        v = 1'b0;
`endif
        return {v, t};
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [65:0] exp_q[$];
    logic [65:0] exp_v;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL %s_drain: got %h required %h", tag, obs, exp_v);
                end
            end
            next_cycle();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_lost: %0d results missing, required 0", tag, exp_q.size());
        end
        exp_q.delete();
        repeat (2) next_cycle();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 66'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b obs=%h in_ready=%b required 0/0/1",
                     out_valid, obs, in_ready);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        next_cycle();
        $display("reset: done");
    endtask

    task automatic test_carry_chain();
        int lat;
        A = '1; B = '0; C0 = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL carry_latency: got %0d cycles required 4", lat);
        end
        checks++;
        if (obs !== {1'b0, 1'b1, 64'd0}) begin
            errors++;
            $display("FAIL carry_chain: got %h required %h", obs, {1'b0, 1'b1, 64'd0});
        end
        $display("carry_chain: latency=%0d S=%h C_Out=%b", lat, S, C_Out);
        next_cycle();
        repeat (2) next_cycle();
    endtask

    task automatic test_streaming();
        int n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 104; i++) begin
            in_valid = (i < 100);
            A = rand64(); B = rand64(); C0 = 1'($urandom);
            @(negedge clk);
            if (i < 100) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready: cycle %0d in_ready=%b required 1", i, in_ready);
                end
            end
            if (i >= 4) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap: cycle %0d out_valid=%b required 1", i, out_valid);
                end
            end
            if (out_valid) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h required no result", obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL stream_data: got %h required %h", obs, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(A, B, C0));
            next_cycle();
        end
        $display("streaming: %0d results observed", n_out);
        drain("stream");
    endtask

    task automatic test_backpressure();
        logic [65:0] held = '0;
        bit          have_held = 0;
        for (int i = 0; i < 24; i++) begin
            in_valid  = 1'b1;
            out_ready = !(i >= 8 && i < 14);
            A = rand64(); B = rand64(); C0 = 1'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL bp_ready: cycle %0d in_ready=%b out_valid=%b out_ready=%b",
                         i, in_ready, out_valid, out_ready);
            end
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    checks++;
                    if (obs !== held) begin
                        errors++;
                        $display("FAIL bp_stable: got %h required %h", obs, held);
                    end
                end
                held = obs;
                have_held = 1;
            end else begin
                have_held = 0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: got %h required no result", obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL bp_data: got %h required %h", obs, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(A, B, C0));
            next_cycle();
        end
        $display("backpressure: %0d results pending at release", exp_q.size());
        drain("bp");
    endtask

    task automatic test_random_handshake();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A = rand64(); B = rand64(); C0 = 1'($urandom);
            @(negedge clk);
            if (!out_valid) begin
                checks++;
                if (obs !== 66'd0) begin
                    errors++;
                    $display("FAIL idle_zero: got %h required 0", obs);
                end
            end else if (out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got %h required no result", obs);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (obs !== exp_v) begin
                        errors++;
                        $display("FAIL rand_data: got %h required %h", obs, exp_v);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(A, B, C0));
            next_cycle();
        end
        $display("random_handshake: %0d results pending", exp_q.size());
        drain("rand");
    endtask

    task automatic test_reset_midflight();
        int lat;
        // Three operations in flight, none completed yet
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; A = rand64(); B = rand64(); C0 = 1'($urandom);
            next_cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 66'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_outputs: out_valid=%b obs=%h in_ready=%b", out_valid, obs, in_ready);
        end
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale: cycle %0d out_valid=%b required 0", i, out_valid);
            end
            next_cycle();
        end
        // Fresh operation gets full latency
        in_valid = 1'b1; A = rand64(); B = rand64(); C0 = 1'($urandom);
        exp_v = model(A, B, C0);
        @(negedge clk);
        next_cycle();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; break; end
        end
        checks++;
        if (lat != 4 || obs !== exp_v) begin
            errors++;
            $display("FAIL midrst_new: latency %0d obs %h required 4 and %h", lat, obs, exp_v);
        end
        next_cycle();
        // Asynchronous reset while a result is being presented and stalled
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; A = rand64(); B = rand64(); C0 = 1'($urandom);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_fill: out_valid=%b required 1", out_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 66'd0) begin
            errors++;
            $display("FAIL midrst_async: out_valid=%b obs=%h required 0/0", out_valid, obs);
        end
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale2: out_valid=%b required 0", out_valid);
            end
            next_cycle();
        end
        $display("reset_midflight: new op latency=%0d", lat);
    endtask

    task automatic test_overflow();
        A = 64'h7FFF_FFFF_FFFF_FFFF; B = 64'd1; C0 = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (out_valid !== 1'b1 || S !== 64'h8000_0000_0000_0000 || C_Out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sum: valid=%b S=%h C_Out=%b required 1/8000000000000000/0",
                     out_valid, S, C_Out);
        end
`ifdef PIPELINED_RCA_OVF_EN
        checks++;
        if (OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b required 1", OVF);
        end
`endif
        $display("overflow: S=%h C_Out=%b OVF=%b", S, C_Out, ovf_bit);
        next_cycle();
        repeat (2) next_cycle();
    endtask

    task automatic test_param_sweep();
        int          q8_cyc[$], q32_cyc[$];
        logic [9:0]  q8_exp[$];
        logic [33:0] q32_exp[$];
        logic [8:0]  t8;
        logic [32:0] t32;
        logic        v;
        int          c_acc;
        for (int i = 0; i < 50; i++) begin
            sw_valid = (i < 30);
            a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
            a32 = $urandom;      b32 = $urandom;      c32 = 1'($urandom);
            @(negedge clk);
            if (ov8) begin
                checks++;
                if (q8_exp.size() == 0) begin
                    errors++;
                    $display("FAIL sweep8_extra: got %h", {ovf8, co8, s8});
                end else begin
                    c_acc = q8_cyc.pop_front();
                    if ({ovf8, co8, s8} !== q8_exp[0] || cyc - c_acc != 1) begin
                        errors++;
                        $display("FAIL sweep8: got %h latency %0d required %h latency 1",
                                 {ovf8, co8, s8}, cyc - c_acc, q8_exp[0]);
                    end
                    void'(q8_exp.pop_front());
                end
            end
            if (ov32) begin
                checks++;
                if (q32_exp.size() == 0) begin
                    errors++;
                    $display("FAIL sweep32_extra: got %h", {ovf32, co32, s32});
                end else begin
                    c_acc = q32_cyc.pop_front();
                    if ({ovf32, co32, s32} !== q32_exp[0] || cyc - c_acc != 8) begin
                        errors++;
                        $display("FAIL sweep32: got %h latency %0d required %h latency 8",
                                 {ovf32, co32, s32}, cyc - c_acc, q32_exp[0]);
                    end
                    void'(q32_exp.pop_front());
                end
            end
            if (sw_valid && rdy8) begin
                t8 = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
`ifdef PIPELINED_RCA_OVF_EN
                v = (a8[7] == b8[7]) && (t8[7] != a8[7]);
`else
                v = 1'b0;
`endif
                q8_exp.push_back({v, t8});
                q8_cyc.push_back(cyc);
            end
            if (sw_valid && rdy32) begin
                t32 = {1'b0, a32} + {1'b0, b32} + {32'd0, c32};
`ifdef PIPELINED_RCA_OVF_EN
                v = (a32[31] == b32[31]) && (t32[31] != a32[31]);
`else
                v = 1'b0;
`endif
                q32_exp.push_back({v, t32});
                q32_cyc.push_back(cyc);
            end
            next_cycle();
        end
        checks++;
        if (q8_exp.size() != 0 || q32_exp.size() != 0) begin
            errors++;
            $display("FAIL sweep_lost: pending 8-bit=%0d 32-bit=%0d required 0/0",
                     q8_exp.size(), q32_exp.size());
        end
        $display("param_sweep: 8/8 and 32/4 instances streamed 30 ops each");
    endtask

    initial begin
        test_reset();
        test_carry_chain();
        test_streaming();
        test_backpressure();
        test_random_handshake();
        test_reset_midflight();
        test_overflow();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
